// File: rtl/demux_pkg.sv
// Shared constants and types for the registered 1-to-4 demultiplexer.
package demux_pkg;

  localparam int SEL_W     = 2;
  localparam int NUM_LANES = 4;

  typedef logic [SEL_W-1:0] lane_idx_t;

endpackage : demux_pkg

// File: rtl/demux_sel_decode.sv
// Combinational one-hot decode of the lane select; unknown selects enable no lane.
module demux_sel_decode
  import demux_pkg::*;
(
  input  lane_idx_t              sel,
  output logic [NUM_LANES-1:0]   onehot
);

  always_comb begin
    onehot = '0;
    case (sel)
      2'd0:    onehot = 4'b0001;
      2'd1:    onehot = 4'b0010;
      2'd2:    onehot = 4'b0100;
      2'd3:    onehot = 4'b1000;
      default: onehot = '0;
    endcase
  end

endmodule : demux_sel_decode

// File: rtl/demux_1to4.sv
// Registered 1-to-4 demux: selected lane gets in, the others get zero, one cycle later.
module demux_1to4
  import demux_pkg::*;
#(
  parameter int DATA_W = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_W-1:0]       in,
  input  logic [SEL_W-1:0]        sel,
  output logic [0:4*DATA_W-1]     y
);

  logic [NUM_LANES-1:0]          onehot;
  logic [0:NUM_LANES*DATA_W-1]   lanes_next;

  demux_sel_decode u_decode (
    .sel    (sel),
    .onehot (onehot)
  );

  // Lane 0 sits at the left (low index) end of the ascending output vector.
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    assign lanes_next[k*DATA_W +: DATA_W] = in & {DATA_W{onehot[k]}};
  end

  always_ff @(posedge clk) begin
    if (rst) y <= '0;
    else     y <= lanes_next;
  end

endmodule : demux_1to4

// File: tb/tb_demux_1to4.sv
// Scoreboard bench for demux_1to4 at DATA_W=1 and DATA_W=8 driven in lockstep.
module tb_demux_1to4;

  typedef struct {
    logic [0:3]  y1;
    logic [0:31] y8;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [0:0]  in1;
  logic [7:0]  in8;
  logic [1:0]  sel;
  logic [0:3]  y1;
  logic [0:31] y8;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  demux_1to4 #(.DATA_W(1)) u_dut1 (
    .clk (clk), .rst (rst), .in (in1), .sel (sel), .y (y1)
  );

  demux_1to4 #(.DATA_W(8)) u_dut8 (
    .clk (clk), .rst (rst), .in (in8), .sel (sel), .y (y8)
  );

  task automatic check(input string name, input logic [0:3] e1, input logic [0:31] e8);
    n_tests++;
    if (y1 !== e1 || y8 !== e8) begin
      n_fail++;
      $display("FAIL %s: got y1=%b y8=%h, expected y1=%b y8=%h", name, y1, y8, e1, e8);
    end
  endtask

  // Drive between edges; the response appears after the following rising edge.
  task automatic apply(input logic r, input logic i1, input logic [7:0] i8,
                       input logic [1:0] s, input logic [0:3] e1,
                       input logic [0:31] e8, input string name);
    exp_t e;
    @(negedge clk);
    rst = r; in1 = i1; in8 = i8; sel = s;
    e.y1 = e1; e.y8 = e8; e.name = name;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check(e.name, e.y1, e.y8);
      end
    end
  end

  initial begin : driver
    rst = 1'b1; in1 = 1'b1; in8 = 8'hA5; sel = 2'd0;

    apply(1, 1, 8'hA5, 2'd0, 4'b0000, 32'h00000000, "reset_1");
    apply(1, 1, 8'hA5, 2'd0, 4'b0000, 32'h00000000, "reset_2");
    apply(0, 1, 8'hA5, 2'd0, 4'b1000, 32'hA5000000, "release_sel0");
    apply(0, 1, 8'hA5, 2'd1, 4'b0100, 32'h00A50000, "sweep_sel1");
    apply(0, 1, 8'hA5, 2'd2, 4'b0010, 32'h0000A500, "sweep_sel2");
    apply(0, 1, 8'hA5, 2'd3, 4'b0001, 32'h000000A5, "sweep_sel3");
    apply(0, 0, 8'h00, 2'd0, 4'b0000, 32'h00000000, "zero_sel0");
    apply(0, 0, 8'h00, 2'd1, 4'b0000, 32'h00000000, "zero_sel1");
    apply(0, 0, 8'h00, 2'd2, 4'b0000, 32'h00000000, "zero_sel2");
    apply(0, 0, 8'h00, 2'd3, 4'b0000, 32'h00000000, "zero_sel3");
    apply(0, 1, 8'hA5, 2'd2, 4'b0010, 32'h0000A500, "pre_midrst");
    apply(1, 1, 8'hA5, 2'd2, 4'b0000, 32'h00000000, "midrst");
    apply(0, 1, 8'hA5, 2'd2, 4'b0010, 32'h0000A500, "post_midrst");
    apply(0, 1, 8'h3C, 2'd1, 4'b0100, 32'h003C0000, "wide_3c_sel1");
    apply(0, 1, 8'hFF, 2'd3, 4'b0001, 32'h000000FF, "wide_ff_sel3");
    apply(0, 1, 8'hA5, 2'd0, 4'b1000, 32'hA5000000, "lat_sel0");

    // Select moves to 3 mid-cycle: output must still hold lane 0 until the edge.
    apply(0, 1, 8'hA5, 2'd3, 4'b0001, 32'h000000A5, "lat_sel3");
    #1;
    check("lat_hold", 4'b1000, 32'hA5000000);

    repeat (3) @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_demux_1to4
